// File: rtl/lc4_mmio_responder.sv
// lc4_mmio_responder: LC4 device page serving switches, LEDs, an interval timer and a console-output FIFO.
module lc4_mmio_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [15:0] DEV_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic [15:0] i_addr,
  input  logic        i_re,
  input  logic        i_we,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_hit,
  input  logic [7:0]  switch_data,
  output logic [7:0]  led_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] sw_s1, sw_s2;
  logic [15:0] tir, cnt;
  logic flag;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [3:0] off;
  logic full, push, pop, tir_wr, tsr_rd, expire;
  assign off = i_addr[3:0];
  assign o_hit = i_addr[15:4] == DEV_BASE[15:4];
  assign full = count == CW'(FIFO_DEPTH);
  assign tx_valid = count != '0;
  assign tx_data = tx_valid ? mem[rp] : '0;
  assign push = i_we & o_hit & (off == 4'hA) & gwe & ~full;
  assign pop = tx_valid & tx_ready & gwe;
  assign tir_wr = i_we & o_hit & (off == 4'h6) & gwe;
  assign tsr_rd = i_re & o_hit & (off == 4'h4) & gwe;
  assign expire = (tir != '0) && (cnt == tir - 16'd1);
  always_comb
    o_rdata = !o_hit       ? 16'h0000 :
              off == 4'h0  ? {8'h00, sw_s2} :
              off == 4'h2  ? {8'h00, led_data} :
              off == 4'h4  ? {flag, 15'h0000} :
              off == 4'h6  ? tir :
              off == 4'h8  ? {~full, 11'h000, 4'(count)} :
                             16'h0000;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      led_data <= '0;
    end else if (gwe) begin
      sw_s1 <= switch_data;
      sw_s2 <= sw_s1;
      if (i_we && o_hit && off == 4'h2) led_data <= i_wdata[7:0];
    end
  // A TIR write restarts the interval and beats both expiry and read-clear.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tir <= '0;
      cnt <= '0;
      flag <= 1'b0;
    end else if (tir_wr) begin
      tir <= i_wdata;
      cnt <= '0;
      flag <= 1'b0;
    end else if (gwe) begin
      cnt <= (tir == '0 || expire) ? '0 : cnt + 16'd1;
      flag <= expire | (flag & ~tsr_rd);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= i_wdata[7:0];
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_lc4_mmio_responder.sv
// tb_lc4_mmio_responder: vector table for the register map plus scoreboarded FIFO and timer sequences.
module tb_lc4_mmio_responder;
  logic clk = 0, rst = 1, gwe = 1, i_re = 0, i_we = 0, tx_ready = 0, o_hit, tx_valid;
  logic [15:0] i_addr = 0, i_wdata = 0, o_rdata;
  logic [7:0] switch_data = 0, led_data, tx_data;
  int checks = 0, failures = 0, pops = 0;
  logic [7:0] exp_q [$];
  typedef struct { logic [15:0] addr; logic [15:0] rdata; logic hit; } rd_vec_t;
  rd_vec_t tab [19];

  lc4_mmio_responder #(.FIFO_DEPTH(4), .DEV_BASE(16'hFE00)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .i_addr(i_addr), .i_re(i_re), .i_we(i_we),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_hit(o_hit), .switch_data(switch_data),
    .led_data(led_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
    i_addr = addr;
    #1;
    chk(name, o_rdata, exp);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    i_we = 1;
    i_addr = addr;
    i_wdata = data;
    step();
    i_we = 0;
  endtask

  // Acceptance is judged on the occupancy before the push edge, as the FIFO does.
  task automatic push(input logic [7:0] b);
    if (exp_q.size() < 4) exp_q.push_back(b);
    wr(16'hFE0A, {8'hEE, b});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && tx_valid; i++) step();
    chk({name, "_valid"}, {15'h0, tx_valid}, 16'h0);
    chk({name, "_left"}, 16'(exp_q.size()), 16'h0);
  endtask

  always @(negedge clk)
    if (!rst && gwe && tx_valid && tx_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected got=%h expected=none", tx_data);
      end else chk("tx_data", {8'h0, tx_data}, {8'h0, exp_q.pop_front()});
    end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) tab[i] = '{16'hFE00 + 16'(i), (i == 8) ? 16'h8000 : 16'h0, 1'b1};
    tab[16] = '{16'h1234, 16'h0, 1'b0};
    tab[17] = '{16'hFE18, 16'h0, 1'b0};
    tab[18] = '{16'hFDF8, 16'h0, 1'b0};
    #2;
    chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0);
    repeat (2) step();
    rst = 0;
    step();
    for (int i = 0; i < 19; i++) begin
      i_addr = tab[i].addr;
      #1;
      chk($sformatf("rd_%0d", i), o_rdata, tab[i].rdata);
      chk($sformatf("hit_%0d", i), {15'h0, o_hit}, {15'h0, tab[i].hit});
    end
    chk("rst_led", {8'h0, led_data}, 16'h0);
    chk("rst_txv", {15'h0, tx_valid}, 16'h0);
    wr(16'hFE02, 16'h12A5);
    chk("led", {8'h0, led_data}, 16'h00A5);
    rd(16'hFE02, 16'h00A5, "ledr");
    wr(16'hFE03, 16'h00FF);
    wr(16'hFE00, 16'h00FF);
    chk("led_odd", {8'h0, led_data}, 16'h00A5);
    switch_data = 8'h3C;
    step();
    rd(16'hFE00, 16'h0000, "swr_1");
    step();
    rd(16'hFE00, 16'h003C, "swr_2");
    gwe = 0;
    switch_data = 8'hC3;
    i_we = 1;
    i_addr = 16'hFE02;
    i_wdata = 16'h0055;
    repeat (5) step();
    i_we = 0;
    rd(16'hFE00, 16'h003C, "swr_frozen");
    chk("led_frozen", {8'h0, led_data}, 16'h00A5);
    gwe = 1;
    wr(16'hFE06, 16'h0005);
    rd(16'hFE06, 16'h0005, "tir");
    repeat (4) step();
    rd(16'hFE04, 16'h0000, "tsr_4");
    step();
    rd(16'hFE04, 16'h8000, "tsr_5");
    i_re = 1;
    step();
    i_re = 0;
    rd(16'hFE04, 16'h0000, "tsr_clr");
    repeat (3) step();
    rd(16'hFE04, 16'h0000, "tsr_again_4");
    step();
    rd(16'hFE04, 16'h8000, "tsr_again_5");
    wr(16'hFE06, 16'h0001);
    rd(16'hFE04, 16'h0000, "tir_wr_clr");
    step();
    rd(16'hFE04, 16'h8000, "tir1_set");
    i_re = 1;
    step();
    i_re = 0;
    rd(16'hFE04, 16'h8000, "set_wins");
    wr(16'hFE06, 16'h0000);
    for (int i = 0; i < 50; i++) begin
      step();
      rd(16'hFE04, 16'h0000, "tir0_idle");
    end
    for (int b = 1; b <= 5; b++) push(8'(b));
    rd(16'hFE08, 16'h0004, "csr_full");
    pops = 0;
    tx_ready = 1;
    drain("drain4");
    chk("pops4", 16'(pops), 16'd4);
    rd(16'hFE08, 16'h8000, "csr_empty");
    tx_ready = 0;
    for (int b = 0; b < 4; b++) push(8'hA0 + 8'(b));
    tx_ready = 1;
    push(8'h77);
    rd(16'hFE08, 16'h8003, "csr_full_pop");
    drain("drain_full");
    tx_ready = 0;
    push(8'h10);
    tx_ready = 1;
    for (int b = 0; b < 10; b++) begin
      push(8'h20 + 8'(b));
      rd(16'hFE08, 16'h8001, "csr_steady");
    end
    drain("drain_wrap");
    tx_ready = 0;
    wr(16'hFE06, 16'h0005);
    for (int b = 0; b < 3; b++) push(8'h50 + 8'(b));
    rd(16'hFE08, 16'h8003, "csr_pre_rst");
    rd(16'hFE04, 16'h0000, "tsr_pre_rst");
    #2;
    rst = 1;
    exp_q.delete();
    #1;
    chk("rst_mid_txv", {15'h0, tx_valid}, 16'h0);
    chk("rst_mid_txd", {8'h0, tx_data}, 16'h0);
    chk("rst_mid_led", {8'h0, led_data}, 16'h0);
    rd(16'hFE08, 16'h8000, "rst_mid_csr");
    rd(16'hFE06, 16'h0000, "rst_mid_tir");
    rd(16'hFE04, 16'h0000, "rst_mid_tsr");
    step();
    rst = 0;
    step();
    chk("post_rst_txv", {15'h0, tx_valid}, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
